// File: rtl/key_action_pkg.sv
// -----------------------------------------------------------------------------
// key_action_pkg
// Shared constants for the key action decoder:
//   - movement codes sent to the game-logic/player-position block
//   - 3-bit FSM state encoding (also visible on the decoder's dbg_state port)
// No ports (package).
// -----------------------------------------------------------------------------
package key_action_pkg;

    // Movement codes
    localparam logic [2:0] MV_NONE       = 3'b000;
    localparam logic [2:0] MV_BIG_JUMP   = 3'b001;
    localparam logic [2:0] MV_SMALL_JUMP = 3'b010;
    localparam logic [2:0] MV_CROUCH     = 3'b011;
    localparam logic [2:0] MV_DROP       = 3'b100;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_JUMP_HOLD    = 3'd1;
    localparam logic [2:0] ST_JUMP_EMIT    = 3'd2;
    localparam logic [2:0] ST_CROUCH_HOLD  = 3'd3;
    localparam logic [2:0] ST_DROP_HOLD    = 3'd4;
    localparam logic [2:0] ST_DROP_EMIT    = 3'd5;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd6;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One push-button input path: 2-flop synchroniser followed by a stability
// counter. The debounced level takes the synced value once the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears
// the counter. Raw edge to o_db edge latency is 2 + DEBOUNCE_CYCLES cycles.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   i_key  in   raw key level (1 = pressed), asynchronous to clk
//   o_db   out  debounced key level
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_db
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db) begin
                // This cycle is the DEBOUNCE_CYCLES-th consecutive mismatch.
                if (r_cnt == LP_CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/key_action_decoder.sv
// -----------------------------------------------------------------------------
// key_action_decoder
// Debounces NUM_KEYS push buttons and turns the jump/crouch/drop keys into
// movement codes for the player-position block. Jump presses are classified
// big/small by hold length (single threshold, auto-fire at MAX_HOLD).
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   keys        in   raw key levels [NUM_KEYS], 1 = pressed, async to clk
//   enable      in   1 = new actions may start from IDLE
//   movement    out  000 none, 001 big jump, 010 small jump, 011 crouch, 100 drop
//   move_valid  out  high whenever movement != 000
//   busy        out  high in every state except IDLE
//   dbg_state   out  current FSM state (key_action_pkg ST_* encoding)
//   dbg_db      out  debounced key levels [NUM_KEYS]
// Output semantics: movement/move_valid form a valid-only interface with no
// ready; the consumer must take the code on every cycle move_valid is high.
// Jump and drop codes are one-cycle strobes, crouch is a level held while the
// key is down.
// -----------------------------------------------------------------------------
module key_action_decoder
    import key_action_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int JUMP_IDX        = 0,
    parameter int CROUCH_IDX      = 1,
    parameter int DROP_IDX        = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 26,
    parameter int LONG_THRESH     = 10000000,
    parameter int MAX_HOLD        = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                enable,
    output logic [2:0]          movement,
    output logic                move_valid,
    output logic                busy,
    output logic [2:0]          dbg_state,
    output logic [NUM_KEYS-1:0] dbg_db
);

    localparam logic [CNT_W-1:0] LP_LONG      = CNT_W'(LONG_THRESH);
    localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [NUM_KEYS-1:0] w_db;
    logic [2:0]          w_m;         // {drop, crouch, jump} debounced
    logic                w_m_any;
    logic                w_m_one;
    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [2:0]          r_movement;
    logic [2:0]          w_next_mv;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic                w_hold_clr;
    logic                w_hold_inc;
    logic                w_big;

    // ---------------- input path ----------------
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .i_key (keys[gi]),
            .o_db  (w_db[gi])
        );
    end

    assign w_m     = {w_db[DROP_IDX], w_db[CROUCH_IDX], w_db[JUMP_IDX]};
    assign w_m_any = (w_m != 3'b000);
    // Exactly one mapped key: non-zero and a power of two.
    assign w_m_one = w_m_any && ((w_m & (w_m - 3'b001)) == 3'b000);

    // ---------------- FSM ----------------
    always_comb begin
        w_next_state = r_state;
        w_hold_clr   = 1'b0;
        w_hold_inc   = 1'b0;
        w_big        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_m_any) begin
                    if (!w_m_one) begin
                        w_next_state = ST_RELEASE_WAIT;   // chord rejected
                    end else if (w_m[0]) begin
                        w_next_state = ST_JUMP_HOLD;
                        w_hold_clr   = 1'b1;
                    end else if (w_m[1]) begin
                        w_next_state = ST_CROUCH_HOLD;
                    end else begin
                        w_next_state = ST_DROP_HOLD;
                    end
                end
            end
            ST_JUMP_HOLD: begin
                // hold_cnt freezes on exit so it still classifies the press.
                if (!w_db[JUMP_IDX]) begin
                    w_next_state = ST_JUMP_EMIT;
                    w_big        = (r_hold_cnt >= LP_LONG);
                end else if (r_hold_cnt == LP_HOLD_LAST) begin
                    w_next_state = ST_JUMP_EMIT;
                    w_big        = 1'b1;
                end else begin
                    w_hold_inc   = 1'b1;
                end
            end
            ST_JUMP_EMIT:   w_next_state = ST_RELEASE_WAIT;
            ST_CROUCH_HOLD: if (!w_db[CROUCH_IDX]) w_next_state = ST_IDLE;
            ST_DROP_HOLD:   if (!w_db[DROP_IDX]) w_next_state = ST_DROP_EMIT;
            ST_DROP_EMIT:   w_next_state = ST_RELEASE_WAIT;
            ST_RELEASE_WAIT: if (!w_m_any) w_next_state = ST_IDLE;
            default:        w_next_state = ST_IDLE;
        endcase
    end

    // Movement is registered alongside the state so it is a pure Moore output.
    always_comb begin
        w_next_mv = MV_NONE;
        case (w_next_state)
            ST_JUMP_EMIT:   w_next_mv = w_big ? MV_BIG_JUMP : MV_SMALL_JUMP;
            ST_CROUCH_HOLD: w_next_mv = MV_CROUCH;
            ST_DROP_EMIT:   w_next_mv = MV_DROP;
            default:        w_next_mv = MV_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_movement <= MV_NONE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_movement <= w_next_mv;
            if (w_hold_clr) begin
                r_hold_cnt <= '0;
            end else if (w_hold_inc) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign movement   = r_movement;
    assign move_valid = (r_movement != MV_NONE);
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;
    assign dbg_db     = w_db;

endmodule

// File: tb/tb_key_action_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_action_decoder
// Bench for key_action_decoder with DEBOUNCE_CYCLES=4, LONG_THRESH=16,
// MAX_HOLD=64 and a fourth, unmapped key.
// Timing used by the expectations: a key driven at a negedge shows on the
// debounced level after 2 + 4 = 6 clock edges and on movement/state one edge
// later (7). A raw press of H cycles leaves hold_cnt = H-1 when the release
// reaches the FSM, so H=16 is small (15) and H=17 is big (16). Auto-fire:
// JUMP_HOLD entered at edge 7 with hold_cnt 0, hold_cnt 63 at edge 70, big
// jump strobe at edge 71.
// -----------------------------------------------------------------------------
module tb_key_action_decoder;
    import key_action_pkg::*;

    localparam int NK = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NK-1:0] keys = '0;
    logic          enable = 1'b1;
    logic [2:0]    movement;
    logic          move_valid;
    logic          busy;
    logic [2:0]    dbg_state;
    logic [NK-1:0] dbg_db;

    always #5 clk = ~clk;

    key_action_decoder #(
        .NUM_KEYS        (NK),
        .JUMP_IDX        (0),
        .CROUCH_IDX      (1),
        .DROP_IDX        (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8),
        .LONG_THRESH     (16),
        .MAX_HOLD        (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keys       (keys),
        .enable     (enable),
        .movement   (movement),
        .move_valid (move_valid),
        .busy       (busy),
        .dbg_state  (dbg_state),
        .dbg_db     (dbg_db)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Output monitor: each new non-zero movement code is popped against the
    // expected queue; jump/drop codes must last exactly one cycle.
    logic [2:0] prev_mv  = MV_NONE;
    int         run_len  = 0;
    logic       saw_busy = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            check("valid_vs_movement", int'(move_valid), int'(movement != MV_NONE));
            if (busy) saw_busy = 1'b1;
            if (movement != prev_mv) begin
                if (prev_mv == MV_BIG_JUMP || prev_mv == MV_SMALL_JUMP || prev_mv == MV_DROP)
                    check("strobe_len", run_len, 1);
                if (movement != MV_NONE) begin
                    if (exp_q.size() == 0) check("unexpected_strobe", int'(movement), int'(MV_NONE));
                    else check("strobe_code", int'(movement), int'(exp_q.pop_front()));
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_mv = movement;
        end else begin
            prev_mv = MV_NONE;
            run_len = 0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_move(input logic [2:0] code, input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (movement == code) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int found);
        found = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (dbg_state == st) begin
                found = 1;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NK-1:0] keys;
        int            hold;
        logic          en;
        logic [2:0]    exp_mv;
        logic          exp_busy;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int lat;
    int found;
    int bad;

    initial begin
        vecs[0] = '{4'b0001, 16, 1'b1, MV_SMALL_JUMP, 1'b1};  // hold_cnt 15
        vecs[1] = '{4'b0001, 17, 1'b1, MV_BIG_JUMP,   1'b1};  // hold_cnt 16
        vecs[2] = '{4'b0001,  6, 1'b1, MV_SMALL_JUMP, 1'b1};
        vecs[3] = '{4'b0100, 10, 1'b1, MV_DROP,       1'b1};
        vecs[4] = '{4'b0010, 12, 1'b1, MV_CROUCH,     1'b1};
        vecs[5] = '{4'b0101, 10, 1'b1, MV_NONE,       1'b1};  // chord
        vecs[6] = '{4'b0011, 10, 1'b1, MV_NONE,       1'b1};  // chord
        vecs[7] = '{4'b0100, 10, 1'b0, MV_NONE,       1'b0};  // disabled
        vecs[8] = '{4'b1000, 10, 1'b1, MV_NONE,       1'b0};  // unmapped key
        vecs[9] = '{4'b0001, 40, 1'b1, MV_BIG_JUMP,   1'b1};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_movement", int'(movement), int'(MV_NONE));
        check("reset_valid", int'(move_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_state", int'(dbg_state), int'(ST_IDLE));
        check("reset_db", int'(dbg_db), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // table-driven presses
        for (int i = 0; i < NV; i++) begin
            enable   = vecs[i].en;
            saw_busy = 1'b0;
            if (vecs[i].exp_mv != MV_NONE) exp_q.push_back(vecs[i].exp_mv);
            keys = vecs[i].keys;
            repeat (vecs[i].hold) @(negedge clk);
            keys = '0;
            repeat (25) @(negedge clk);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
            check($sformatf("vec%0d_busy_seen", i), int'(saw_busy), int'(vecs[i].exp_busy));
            check($sformatf("vec%0d_idle", i), int'(busy), 0);
            exp_q.delete();
        end
        enable = 1'b1;

        // auto-fire: held 200 cycles, one big strobe at edge 71
        exp_q.push_back(MV_BIG_JUMP);
        keys = 4'b0001;
        wait_move(MV_BIG_JUMP, 100, lat);
        check("autofire_latency", lat, 71);
        repeat (200 - ((lat > 0) ? lat : 100)) @(negedge clk);
        check("autofire_held_busy", int'(busy), 1);
        keys = '0;
        repeat (25) @(negedge clk);
        check("autofire_pending", exp_q.size(), 0);
        check("autofire_idle", int'(busy), 0);
        exp_q.push_back(MV_SMALL_JUMP);
        keys = 4'b0001;
        repeat (8) @(negedge clk);
        keys = '0;
        repeat (25) @(negedge clk);
        check("after_autofire_press", exp_q.size(), 0);
        exp_q.delete();

        // crouch glitches shorter than the debounce window
        saw_busy = 1'b0;
        for (int g = 0; g < 4; g++) begin
            keys = 4'b0010;
            repeat (3) @(negedge clk);
            keys = '0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_no_busy", int'(saw_busy), 0);
        check("glitch_db", int'(dbg_db), 0);

        // stable crouch: level output from edge 7 after press to edge 7 after release
        exp_q.push_back(MV_CROUCH);
        keys = 4'b0010;
        wait_move(MV_CROUCH, 30, lat);
        check("crouch_on_latency", lat, 7);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (movement != MV_CROUCH) bad++;
        end
        check("crouch_continuous", bad, 0);
        keys = '0;
        wait_move(MV_NONE, 30, lat);
        check("crouch_off_latency", lat, 7);
        repeat (5) @(negedge clk);
        check("crouch_idle", int'(busy), 0);
        exp_q.delete();

        // chord: busy stays high until every mapped key is released
        keys = 4'b0101;
        repeat (20) @(negedge clk);
        check("chord_busy", int'(busy), 1);
        check("chord_state", int'(dbg_state), int'(ST_RELEASE_WAIT));
        keys = 4'b0001;
        repeat (15) @(negedge clk);
        check("chord_partial_busy", int'(busy), 1);
        keys = '0;
        repeat (15) @(negedge clk);
        check("chord_released_idle", int'(busy), 0);

        // enable dropped during DROP_HOLD: strobe still issued on release
        exp_q.push_back(MV_DROP);
        keys = 4'b0100;
        wait_state(ST_DROP_HOLD, 30, found);
        check("drop_hold_entered", found, 1);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        keys = '0;
        repeat (25) @(negedge clk);
        check("drop_disabled_pending", exp_q.size(), 0);
        check("drop_disabled_idle", int'(busy), 0);
        enable = 1'b1;
        exp_q.delete();

        // drop with jump pressed meanwhile: one drop strobe, IDLE after jump release
        exp_q.push_back(MV_DROP);
        keys = 4'b0100;
        repeat (12) @(negedge clk);
        keys = 4'b0101;
        repeat (12) @(negedge clk);
        keys = 4'b0001;
        wait_move(MV_DROP, 30, lat);
        check("drop_extra_seen", int'(lat > 0), 1);
        repeat (20) @(negedge clk);
        check("drop_extra_wait_busy", int'(busy), 1);
        check("drop_extra_wait_state", int'(dbg_state), int'(ST_RELEASE_WAIT));
        keys = '0;
        repeat (25) @(negedge clk);
        check("drop_extra_idle", int'(busy), 0);
        check("drop_extra_pending", exp_q.size(), 0);
        exp_q.delete();

        // asynchronous reset in the middle of a jump hold
        keys = 4'b0001;
        wait_state(ST_JUMP_HOLD, 30, found);
        check("jump_hold_entered", found, 1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_movement", int'(movement), int'(MV_NONE));
        check("midreset_valid", int'(move_valid), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_state", int'(dbg_state), int'(ST_IDLE));
        @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("midreset_after_busy", int'(busy), 0);
        check("midreset_no_strobe", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
